alu_obf_sched: RTL
==================

// Module: alu_obf_sched
// PURPOSE
//  Shares one locked ALU instance (alu_0_obf) between NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshakes on requests and responses,
//  one operation in flight at a time.
//  Holds the working locking key in a register loaded on command; no operation
//  is granted until a key is loaded. Sits between the requester fabric and the
//  locked datapath.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  WIDTH     8    operand/result width (fixed 8 by the ALU)
//  KEY_W     255  locking_key width presented to the ALU
//  ID_W      2    requester index width, $clog2(NUM_REQ)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst          in   1              asynchronous, active-high reset
//  locking_key  in   KEY_W          key value, sampled only when key_load=1
//  key_load     in   1              1-cycle pulse: capture locking_key
//  key_loaded   out  1              key register valid
//  req_valid    in   NUM_REQ        per-requester request valid
//  req_ready    out  NUM_REQ        per-requester accept (one-hot or zero)
//  req_in1      in   NUM_REQ*WIDTH  operand in1, requester i at [i*W +: W]
//  req_in2      in   NUM_REQ*WIDTH  operand in2
//  req_in3      in   NUM_REQ*WIDTH  operand in3
//  req_sel      in   NUM_REQ        add/sub select per requester
//  rsp_valid    out  1              response valid
//  rsp_ready    in   1              response accept
//  rsp_id       out  ID_W           index of requester served
//  rsp_out1     out  WIDTH          ALU out1 (add/sub result)
//  rsp_out2     out  WIDTH          ALU out2 (in3*constant result)
// BEHAVIOUR
//  Reset: state=KEY_WAIT, key reg=0, key_loaded=0, rr pointer=0,
//   req_ready=0, rsp_valid=0, rsp_id=0, rsp_out1=0, rsp_out2=0.
//  Key: key_load=1 loads key reg and sets key_loaded=1 next cycle (any state).
//   While state is EXEC, the load is deferred one cycle so the in-flight op
//   uses a stable key. key_loaded never clears except by rst.
//  FSM states and transitions:
//   KEY_WAIT: go to GRANT when key_loaded=1.
//   GRANT: req_ready is combinational, one-hot on the first valid requester
//    at or after the rr pointer. If any is valid, capture in1/in2/in3/sel/id
//    and go to EXEC. The pointer becomes granted id+1 (mod NUM_REQ).
//    If none is valid, stay in GRANT and leave the pointer unchanged.
//   EXEC: ALU is driven from the captured regs and the key reg. Register
//    out1/out2/id into the rsp regs, set rsp_valid=1, go to RESP.
//   RESP: hold all rsp_* stable while rsp_valid=1 and rsp_ready=0.
//    On rsp_ready=1: rsp_valid=0 and go to GRANT. No request is granted in RESP.
//  Latency: accept in cycle N (GRANT), rsp_valid=1 in cycle N+2.
//   Max throughput is 1 op per 3 cycles.
//  Arithmetic: results follow the locked ALU exactly, mod 2^WIDTH.
//   out1 = in1-in2 when sel^key[0]=1, else in1+in2.
//   out2 = low WIDTH bits of in3*(0xD6^key[8:1]).
//   Upper key bits are passed through unused.
//  Fairness: a continuously valid requester is granted within NUM_REQ grants.
//  Requester may drop req_valid without a handshake; only valid&ready transfers.
//  rst mid-operation: in-flight op discarded, no response, key must be reloaded.
// STRUCTURE
//  Package alu_obf_pkg: state enum {KEY_WAIT,GRANT,EXEC,RESP}, ALU_WIDTH=8,
//   KEY_W=255, USED_KEY_BITS=9.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant and
//   encoded id. Instantiates alu_0_obf unchanged.
// TESTING
//  1 No key_load, req_valid=4'b0001 for 20 cycles -> req_ready=0, rsp_valid=0.
//  2 key=0, req0 in1=5 in2=7 in3=2 sel=1 -> rsp_out1=0xFE, rsp_out2=0xAC,
//    rsp_id=0, 2 cycles after accept.
//  3 key[0]=1, others 0, same op -> rsp_out1=0x0C (add), rsp_out2=0xAC.
//  4 All 4 requesters valid, rsp_ready=1 -> grant order 0,1,2,3,0.
//    Then only req2 valid after ptr=1 -> req2 granted next.
//  5 rsp_ready=0 for 10 cycles -> rsp_* stable, no new req_ready.
//    Release -> next grant follows.
//  6 rst asserted in EXEC -> all outputs 0 next edge, key_loaded=0,
//    no response emitted.

Source files
------------

// File: rtl/alu_obf_pkg.sv
// Shared types and constants for the locked-ALU scheduler.
//   state_t        : scheduler FSM states
//   ALU_WIDTH      : operand/result width of the locked ALU
//   KEY_W          : width of the locking key presented to the ALU
//   USED_KEY_BITS  : low key bits the ALU actually consumes
package alu_obf_pkg;
    typedef enum logic [1:0] {KEY_WAIT, GRANT, EXEC, RESP} state_t;

    localparam int ALU_WIDTH     = 8;
    localparam int KEY_W         = 255;
    localparam int USED_KEY_BITS = 9;
endpackage

// File: rtl/alu_0_obf.sv
// Locked ALU datapath (combinational).
//   in1, in2, in3 : 8-bit operands
//   sel           : add/sub select, XORed with key[0]
//   locking_key   : KEY_W-bit key; only bits [8:0] affect the result
//   out1          : in1-in2 when sel^key[0], else in1+in2
//   out2          : low 8 bits of in3 * (0xD6 ^ key[8:1])
module alu_0_obf
    import alu_obf_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] in1,
    input  logic [ALU_WIDTH-1:0] in2,
    input  logic [ALU_WIDTH-1:0] in3,
    input  logic                 sel,
    input  logic [KEY_W-1:0]     locking_key,
    output logic [ALU_WIDTH-1:0] out1,
    output logic [ALU_WIDTH-1:0] out2
);
    // Upper key bits are decoys: carried through, never used.
    logic unused_key_bits;
    assign unused_key_bits = ^locking_key[KEY_W-1:USED_KEY_BITS];

    assign out1 = (sel ^ locking_key[0]) ? in1 - in2 : in1 + in2;
    assign out2 = in3 * (8'hD6 ^ locking_key[USED_KEY_BITS-1:1]);
endmodule

// File: rtl/alu_obf_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
//   req : request vector
//   ptr : highest-priority index (must be < NUM_REQ)
//   gnt : one-hot grant (zero when no request)
//   id  : encoded index of the granted requester
//   any : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any
);
    // Rotate so ptr lands at bit 0; the first set bit is then the offset.
    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;

    assign rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        any = 1'b0;
        sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (ID_W+1)'(k);
            end
        end
        if (sum >= (ID_W+1)'(NUM_REQ))
            id = ID_W'(sum - (ID_W+1)'(NUM_REQ));
        else
            id = ID_W'(sum);
        gnt = any ? (NUM_REQ'(1) << id) : '0;
    end
endmodule

// File: rtl/alu_obf_sched.sv
// Shares one locked ALU between NUM_REQ requesters, one op in flight.
//   clk, rst         : clock, async active-high reset
//   locking_key      : key value, captured on key_load
//   key_load         : 1-cycle pulse to load the key
//   key_loaded       : key register valid (sticky until reset)
//   req_valid/ready  : per-requester handshake, ready one-hot or zero
//   req_in1/2/3/sel  : per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready  : response handshake
//   rsp_id/out1/out2 : served requester and ALU results
module alu_obf_sched
    import alu_obf_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int KEY_W   = 255,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KEY_W-1:0]         locking_key,
    input  logic                     key_load,
    output logic                     key_loaded,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    input  logic [NUM_REQ*WIDTH-1:0] req_in3,
    input  logic [NUM_REQ-1:0]       req_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_out1,
    output logic [WIDTH-1:0]         rsp_out2
);
    state_t state, nxt;

    logic [KEY_W-1:0] key_q, key_pend;
    logic             key_pend_vld;

    logic [ID_W-1:0]  ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any, fire;

    logic [WIDTH-1:0] cap_in1, cap_in2, cap_in3;
    logic             cap_sel;
    logic [ID_W-1:0]  cap_id;
    logic [WIDTH-1:0] alu_out1, alu_out2;

    logic [NUM_REQ-1:0][WIDTH-1:0] in1_v, in2_v, in3_v;
    assign in1_v = req_in1;
    assign in2_v = req_in2;
    assign in3_v = req_in3;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .id  (gnt_id),
        .any (gnt_any)
    );

    assign req_ready = (state == GRANT) ? gnt : '0;
    assign fire      = (state == GRANT) && gnt_any;

    alu_0_obf u_alu (
        .in1         (cap_in1),
        .in2         (cap_in2),
        .in3         (cap_in3),
        .sel         (cap_sel),
        .locking_key (key_q),
        .out1        (alu_out1),
        .out2        (alu_out2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= KEY_WAIT;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            KEY_WAIT: if (key_loaded) nxt = GRANT;
            GRANT:    if (gnt_any)    nxt = EXEC;
            EXEC:                     nxt = RESP;
            RESP:     if (rsp_ready)  nxt = GRANT;
            default:                  nxt = KEY_WAIT;
        endcase
    end

    // A load arriving during EXEC is parked for one cycle so the op being
    // evaluated sees a stable key; a fresh load supersedes a parked one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q        <= '0;
            key_pend     <= '0;
            key_pend_vld <= 1'b0;
            key_loaded   <= 1'b0;
        end else if (key_load && state == EXEC) begin
            key_pend     <= locking_key;
            key_pend_vld <= 1'b1;
        end else if (key_load) begin
            key_q        <= locking_key;
            key_loaded   <= 1'b1;
            key_pend_vld <= 1'b0;
        end else if (key_pend_vld) begin
            key_q        <= key_pend;
            key_loaded   <= 1'b1;
            key_pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cap_in1   <= '0;
            cap_in2   <= '0;
            cap_in3   <= '0;
            cap_sel   <= 1'b0;
            cap_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out1  <= '0;
            rsp_out2  <= '0;
        end else begin
            if (fire) begin
                cap_in1 <= in1_v[gnt_id];
                cap_in2 <= in2_v[gnt_id];
                cap_in3 <= in3_v[gnt_id];
                cap_sel <= req_sel[gnt_id];
                cap_id  <= gnt_id;
                ptr     <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == EXEC) begin
                rsp_out1  <= alu_out1;
                rsp_out2  <= alu_out2;
                rsp_id    <= cap_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
